// File: rtl/posicionador_embarcacao.sv
// Ship placement writer: validates a placement, scans the player's fleet memory for
// overlap and a free slot, then writes the encoded 64-bit ship record.
module posicionador_embarcacao #(
    parameter int NUM_REC = 12,
    parameter int BOARD   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        jogador,
    input  logic [2:0]  tipo,
    input  logic [3:0]  x,
    input  logic [3:0]  y,
    input  logic        orientacao,
    input  logic [63:0] memoriaP1,
    input  logic [63:0] memoriaP2,
    output logic [4:0]  addr,
    output logic        wrep1,
    output logic        wrep2,
    output logic [63:0] dado,
    output logic        ready,
    output logic [1:0]  erro
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SCAN,
        WRITE,
        DONE
    } state_t;

    localparam logic [4:0] LAST_ADDR = 5'(NUM_REC - 1);
    localparam logic [4:0] BOARD5    = 5'(BOARD);

    state_t      state_q;
    logic [4:0]  addr_q;
    logic [4:0]  freeAddr_q;
    logic        freeFound_q;
    logic        jogador_q;
    logic [2:0]  tipo_q;
    logic [3:0]  x_q;
    logic [3:0]  y_q;
    logic        orient_q;
    logic        wrep1_q;
    logic        wrep2_q;
    logic [63:0] dado_q;
    logic        ready_q;
    logic [1:0]  erro_q;

    logic [2:0]  shipLen;
    logic [4:0]  endX;
    logic [4:0]  endY;
    logic        boundsOk;
    logic [7:0]  newCells [5];
    logic [63:0] record_d;
    logic [63:0] memWord;
    logic        overlapHit;
    logic        recordFree;
    logic        freeNow;
    logic [4:0]  writeAddr_d;

    always_comb begin
        case (tipo_q)
            3'd1:    shipLen = 3'd5;
            3'd2:    shipLen = 3'd4;
            3'd3:    shipLen = 3'd3;
            3'd4:    shipLen = 3'd3;
            3'd5:    shipLen = 3'd2;
            default: shipLen = 3'd0;
        endcase
    end

    // End-cell coordinates in 5 bits so that x+L-1 beyond 15 cannot wrap into range.
    assign endX = {1'b0, x_q} + (orient_q ? 5'd0 : ({2'b00, shipLen} - 5'd1));
    assign endY = {1'b0, y_q} + (orient_q ? ({2'b00, shipLen} - 5'd1) : 5'd0);
    assign boundsOk = (shipLen != 3'd0) && (x_q != 4'd0) && (y_q != 4'd0) &&
                      (endX <= BOARD5) && (endY <= BOARD5);

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            newCells[i] = 8'h00;
            if (3'(i) < shipLen) begin
                if (orient_q) newCells[i] = {y_q + 4'(i), x_q};
                else          newCells[i] = {y_q, x_q + 4'(i)};
            end
        end
    end

    assign record_d = {16'h0000, shipLen, 2'b00, newCells[4], newCells[3],
                       newCells[2], newCells[1], newCells[0], tipo_q};

    assign memWord = jogador_q ? memoriaP2 : memoriaP1;

    // Empty cells (8'h00) never collide; only the new ship's real cells are nonzero.
    always_comb begin
        overlapHit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                if ((memWord[10+8*i -: 8] != 8'h00) && (newCells[j] != 8'h00) &&
                    (memWord[10+8*i -: 8] == newCells[j]))
                    overlapHit = 1'b1;
            end
        end
    end

    assign recordFree  = (memWord[2:0] == 3'd0);
    assign freeNow     = freeFound_q || recordFree;
    assign writeAddr_d = freeFound_q ? freeAddr_q : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= 5'd0;
            freeAddr_q  <= 5'd0;
            freeFound_q <= 1'b0;
            jogador_q   <= 1'b0;
            tipo_q      <= 3'd0;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            orient_q    <= 1'b0;
            wrep1_q     <= 1'b0;
            wrep2_q     <= 1'b0;
            dado_q      <= 64'h0;
            ready_q     <= 1'b0;
            erro_q      <= 2'b00;
        end else begin
            wrep1_q <= 1'b0;
            wrep2_q <= 1'b0;
            dado_q  <= 64'h0;
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        jogador_q <= jogador;
                        tipo_q    <= tipo;
                        x_q       <= x;
                        y_q       <= y;
                        orient_q  <= orientacao;
                        erro_q    <= 2'b00;
                        state_q   <= CHECK;
                    end
                end
                CHECK: begin
                    if (!boundsOk) begin
                        erro_q  <= 2'b01;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        addr_q      <= 5'd0;
                        freeFound_q <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (overlapHit) begin
                        erro_q  <= 2'b10;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        if (recordFree && !freeFound_q) begin
                            freeFound_q <= 1'b1;
                            freeAddr_q  <= addr_q;
                        end
                        if (addr_q == LAST_ADDR) begin
                            if (freeNow) begin
                                addr_q  <= writeAddr_d;
                                dado_q  <= record_d;
                                wrep1_q <= ~jogador_q;
                                wrep2_q <= jogador_q;
                                state_q <= WRITE;
                            end else begin
                                erro_q  <= 2'b11;
                                ready_q <= 1'b1;
                                state_q <= DONE;
                            end
                        end else begin
                            addr_q <= addr_q + 5'd1;
                        end
                    end
                end
                WRITE: begin
                    ready_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign addr  = addr_q;
    assign wrep1 = wrep1_q;
    assign wrep2 = wrep2_q;
    assign dado  = dado_q;
    assign ready = ready_q;
    assign erro  = erro_q;

endmodule

// File: tb/tb_posicionador_embarcacao.sv
// Bench for posicionador_embarcacao: coordinate-level reference model, per-cycle output
// comparison, directed scenarios plus randomized placements.
module tb_posicionador_embarcacao;

    localparam int NUM_REC = 12;
    localparam int BOARD   = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        jogador;
    logic [2:0]  tipo;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        orientacao;
    logic [63:0] memoriaP1;
    logic [63:0] memoriaP2;
    logic [4:0]  addr;
    logic        wrep1;
    logic        wrep2;
    logic [63:0] dado;
    logic        ready;
    logic [1:0]  erro;

    logic [63:0] mem1 [NUM_REC];
    logic [63:0] mem2 [NUM_REC];

    int checkCount = 0;
    int passCount  = 0;

    int          expCode;
    int          expAddr;
    int          expDone;
    int          expWrite;
    int          expLastScan;
    int          expJog;
    logic [63:0] expRec;

    always #5 clk = ~clk;

    assign memoriaP1 = (addr < 5'd12) ? mem1[addr[3:0]] : 64'h0;
    assign memoriaP2 = (addr < 5'd12) ? mem2[addr[3:0]] : 64'h0;

    posicionador_embarcacao #(.NUM_REC(NUM_REC), .BOARD(BOARD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .jogador    (jogador),
        .tipo       (tipo),
        .x          (x),
        .y          (y),
        .orientacao (orientacao),
        .memoriaP1  (memoriaP1),
        .memoriaP2  (memoriaP2),
        .addr       (addr),
        .wrep1      (wrep1),
        .wrep2      (wrep2),
        .dado       (dado),
        .ready      (ready),
        .erro       (erro)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic int shipLen(input int t);
        case (t)
            1: return 5;
            2: return 4;
            3: return 3;
            4: return 3;
            5: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] encodeShip(input int t, input int sx, input int sy, input bit o);
        logic [63:0] r;
        int len;
        int cx;
        int cy;
        r = 64'h0;
        len = shipLen(t);
        r[2:0]   = 3'(t);
        r[47:45] = 3'(len);
        for (int i = 0; i < len; i++) begin
            cx = o ? sx : sx + i;
            cy = o ? sy + i : sy;
            r = r | (64'(cy * 16 + cx) << (3 + 8 * i));
        end
        return r;
    endfunction

    task automatic clearMem(input int which);
        for (int r = 0; r < NUM_REC; r++) begin
            if (which == 0) mem1[r] = 64'h0;
            else            mem2[r] = 64'h0;
        end
    endtask

    // Expected outcome and per-cycle timeline (m = cycles after the start-sampling edge).
    task automatic predict(input int jog, input int t, input int sx, input int sy, input bit o);
        int len;
        int ex;
        int ey;
        int freeRec;
        int b;
        bit hit;
        logic [63:0] word;
        expJog = jog; expWrite = -1; expAddr = -1; expRec = 64'h0; expLastScan = -1;
        len = shipLen(t);
        ex = o ? sx : sx + len - 1;
        ey = o ? sy + len - 1 : sy;
        if (len == 0 || sx == 0 || sy == 0 || ex > BOARD || ey > BOARD) begin
            expCode = 1; expDone = 1;
            return;
        end
        expRec = encodeShip(t, sx, sy, o);
        freeRec = -1;
        for (int r = 0; r < NUM_REC; r++) begin
            word = (jog != 0) ? mem2[r] : mem1[r];
            hit = 1'b0;
            for (int c = 0; c < 5; c++) begin
                b = int'((word >> (3 + 8 * c)) & 64'hFF);
                if (b != 0) begin
                    for (int i = 0; i < len; i++) begin
                        if ((b % 16) == (o ? sx : sx + i) && (b / 16) == (o ? sy + i : sy)) hit = 1'b1;
                    end
                end
            end
            if (hit) begin
                expCode = 2; expAddr = r; expDone = 2 + r; expLastScan = 1 + r;
                return;
            end
            if (word[2:0] == 3'd0 && freeRec < 0) freeRec = r;
        end
        expLastScan = NUM_REC;
        if (freeRec < 0) begin
            expCode = 3; expDone = NUM_REC + 1;
        end else begin
            expCode = 0; expAddr = freeRec; expWrite = NUM_REC + 1; expDone = NUM_REC + 2;
        end
    endtask

    task automatic checkOutput(input int m);
        check($sformatf("ready m=%0d", m), 64'(ready), 64'(m == expDone));
        check($sformatf("wrep1 m=%0d", m), 64'(wrep1), 64'(m == expWrite && expJog == 0));
        check($sformatf("wrep2 m=%0d", m), 64'(wrep2), 64'(m == expWrite && expJog == 1));
        check($sformatf("dado m=%0d", m), dado, (m == expWrite) ? expRec : 64'h0);
        check($sformatf("erro m=%0d", m), 64'(erro), (m >= expDone) ? 64'(expCode) : 64'h0);
        if (m >= 1 && m <= expLastScan)
            check($sformatf("scan addr m=%0d", m), 64'(addr), 64'(m - 1));
        if (m == expWrite)
            check($sformatf("write addr m=%0d", m), 64'(addr), 64'(expAddr));
    endtask

    // extraStartAt: -1 none, -2 random, else cycle at which a stray start is pulsed.
    task automatic applyStimulus(input int jog, input int t, input int sx, input int sy,
                                 input bit o, input int extraStartAt, input int resetAt);
        int extraAt;
        predict(jog, t, sx, sy, o);
        extraAt = (extraStartAt == -2) ? int'($urandom_range(0, expDone)) : extraStartAt;
        @(negedge clk);
        jogador = 1'(jog); tipo = 3'(t); x = 4'(sx); y = 4'(sy); orientacao = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        jogador = ~jogador; tipo = 3'($urandom); x = 4'($urandom); y = 4'($urandom);
        orientacao = ~orientacao;
        for (int m = 0; m <= expDone + 1; m++) begin
            @(negedge clk);
            checkOutput(m);
            if (m == resetAt) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                check("async rst addr", 64'(addr), 64'h0);
                check("async rst wreps", 64'({wrep1, wrep2}), 64'h0);
                check("async rst dado", dado, 64'h0);
                check("async rst ready", 64'(ready), 64'h0);
                check("async rst erro", 64'(erro), 64'h0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (m == extraAt) begin
                start = 1'b1;
                jogador = 1'($urandom); tipo = 3'($urandom_range(1, 5));
                x = 4'($urandom_range(1, 10)); y = 4'($urandom_range(1, 10));
            end else begin
                start = 1'b0;
            end
        end
        if (expCode == 0) begin
            if (expJog != 0) mem2[expAddr] = expRec;
            else             mem1[expAddr] = expRec;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; jogador = 1'b0; tipo = 3'd0;
        x = 4'd0; y = 4'd0; orientacao = 1'b0;
        clearMem(0);
        clearMem(1);
        #12;
        check("reset addr", 64'(addr), 64'h0);
        check("reset wreps", 64'({wrep1, wrep2}), 64'h0);
        check("reset dado", dado, 64'h0);
        check("reset ready", 64'(ready), 64'h0);
        check("reset erro", 64'(erro), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic horizontal placement into an empty player 1 memory.
        applyStimulus(0, 1, 2, 3, 0, -1, -1);
        check("s1 model len", 64'(expRec[47:45]), 64'd5);
        check("s1 model cell0", 64'(expRec[10:3]), 64'h32);
        check("s1 model cell4", 64'(expRec[42:35]), 64'h36);
        check("s1 model ready cycle", 64'(expDone), 64'd14);
        check("s1 model addr", 64'(expAddr), 64'd0);

        // Bounds and type errors.
        applyStimulus(0, 2, 8, 5, 0, -1, -1);
        check("s2 model code", 64'(expCode), 64'd1);
        check("s2 model ready cycle", 64'(expDone), 64'd1);
        applyStimulus(0, 6, 3, 3, 0, -1, -1);
        check("s2b model code", 64'(expCode), 64'd1);
        applyStimulus(1, 1, 7, 2, 0, -1, -1);
        check("s2c model code", 64'(expCode), 64'd1);

        // Overlap against record 4.
        clearMem(0);
        mem1[4] = encodeShip(5, 5, 5, 0);
        applyStimulus(0, 5, 5, 4, 1, -1, -1);
        check("s3 model code", 64'(expCode), 64'd2);
        check("s3 model ready cycle", 64'(expDone), 64'd6);

        // Full memory, then two free holes.
        for (int r = 0; r < 10; r++) mem1[r] = encodeShip(5, 1, r + 1, 0);
        mem1[10] = encodeShip(5, 5, 1, 0);
        mem1[11] = encodeShip(5, 5, 2, 0);
        applyStimulus(0, 5, 9, 9, 0, -1, -1);
        check("s4 model code", 64'(expCode), 64'd3);
        mem1[3] = 64'h0;
        mem1[7] = 64'h0;
        applyStimulus(0, 5, 9, 9, 0, -1, -1);
        check("s4b model code", 64'(expCode), 64'd0);
        check("s4b model addr", 64'(expAddr), 64'd3);

        // Reset during scan of record 6, then a clean retry.
        clearMem(0);
        applyStimulus(0, 1, 2, 3, 0, -1, 7);
        applyStimulus(0, 1, 2, 3, 0, -1, -1);
        check("s5 model addr", 64'(expAddr), 64'd0);

        // Player 2 with a stray start during scan.
        clearMem(1);
        applyStimulus(1, 3, 4, 4, 1, 5, -1);
        check("s6 model code", 64'(expCode), 64'd0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) clearMem(0);
            if ($urandom_range(0, 9) == 0) clearMem(1);
            applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? -2 : -1, -1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
